// File: rtl/div_r4_seq.sv
// Sequential signed radix-4 divider: 32-bit dividend by 11-bit divisor.
// Two quotient bits per cycle on magnitudes, sign fix-up in a final cycle.
// The quotient truncates toward zero and the remainder takes the dividend's sign.
module div_r4_seq #(
    parameter int DW = 32,
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] x,
    input  logic [CW-1:0] y,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [CW-1:0] r,
    output logic          dz,
    output logic          ovf
);

    localparam logic [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            sx;
    logic            sy;
    logic            zdiv;
    logic [DW-1:0]   ax;
    logic [DW-1:0]   qm;
    logic [CW-1:0]   ay;
    logic [CW-1:0]   rem;

    logic [CW+1:0]   rp;
    logic [CW+1:0]   ay1;
    logic [CW+1:0]   ay2;
    logic [CW+1:0]   ay3;
    logic [CW+1:0]   rnext;
    logic [1:0]      k;

    // Magnitude of a two's-complement value; the most negative value maps to 2^(W-1).
    function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [CW-1:0] abs_cw(input logic [CW-1:0] v);
        return v[CW-1] ? (~v + 1'b1) : v;
    endfunction

    // Conditional negation used to restore signs on the magnitude results.
    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [CW-1:0] neg_cw(input logic [CW-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Signed quotient with saturation: a positive result of 2^(DW-1) clips to QMAX.
    function automatic logic [DW-1:0] sat_quot(input logic [DW-1:0] m, input logic neg);
        if (!neg && m == QMIN) return QMAX;
        return neg_dw(m, neg);
    endfunction

    // Radix-4 digit selection: largest k in 0..3 with k*ay <= shifted partial remainder.
    always_comb begin
        rp    = {rem, ax[DW-1:DW-2]};
        ay1   = {2'b00, ay};
        ay2   = {1'b0, ay, 1'b0};
        ay3   = ay2 + ay1;
        k     = 2'd0;
        rnext = rp;
        if (rp >= ay3) begin
            k     = 2'd3;
            rnext = rp - ay3;
        end else if (rp >= ay2) begin
            k     = 2'd2;
            rnext = rp - ay2;
        end else if (rp >= ay1) begin
            k     = 2'd1;
            rnext = rp - ay1;
        end
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sx    <= x[DW-1];
                        sy    <= y[CW-1];
                        ax    <= abs_dw(x);
                        ay    <= abs_cw(y);
                        rem   <= '0;
                        qm    <= '0;
                        cnt   <= 4'd0;
                        zdiv  <= (y == '0);
                        busy  <= 1'b1;
                        state <= (y == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    // rnext < ay <= 2^(CW-1), so the low CW bits hold it exactly
                    rem <= rnext[CW-1:0];
                    qm  <= {qm[DW-3:0], k};
                    ax  <= {ax[DW-3:0], 2'b00};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= FIX;
                end
                FIX: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (zdiv) begin
                        q   <= sx ? QMIN : QMAX;
                        r   <= '0;
                        dz  <= 1'b1;
                        ovf <= 1'b0;
                    end else if (!(sx ^ sy) && qm == QMIN) begin
                        q   <= sat_quot(qm, 1'b0);
                        r   <= '0;
                        dz  <= 1'b0;
                        ovf <= 1'b1;
                    end else begin
                        q   <= sat_quot(qm, sx ^ sy);
                        r   <= neg_cw(rem, sx);
                        dz  <= 1'b0;
                        ovf <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_r4_seq.sv
// Scoreboard bench for div_r4_seq: stimulus pushes expected results computed
// with plain signed / and %, a monitor pops and compares on every done pulse.
module tb_div_r4_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [10:0] y;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [10:0] r;
    logic        dz;
    logic        ovf;

    typedef struct {
        logic [31:0] q;
        logic [10:0] r;
        logic        dz;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;

    div_r4_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .dz   (dz),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: signed division truncating toward zero, with the error cases.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [10:0] b);
        exp_t   e;
        longint sa;
        longint sb_v;
        longint qq;
        longint rr;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (sb_v == 0) begin
            e.q  = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.r  = 11'd0;
            e.dz = 1'b1;
        end else if (sa == -64'sd2147483648 && sb_v == -1) begin
            e.q   = 32'h7FFF_FFFF;
            e.r   = 11'd0;
            e.ovf = 1'b1;
        end else begin
            qq  = sa / sb_v;
            rr  = sa % sb_v;
            e.q = qq[31:0];
            e.r = rr[10:0];
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("q",   64'(q),   64'(e.q));
                chk("r",   64'(r),   64'(e.r));
                chk("dz",  64'(dz),  64'(e.dz));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Issue one operation, wait for its done and check the start-to-done latency.
    task automatic do_op(input logic [31:0] a, input logic [10:0] b);
        int n0;
        int w;
        int start_cyc;
        w = 0;
        while (busy !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        sb.push_back(ref_div(a, b));
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        n0        = done_cnt;
        w         = 0;
        while (done_cnt == n0 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (done_cnt == n0) begin
            chk("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end else begin
            chk("latency", 64'(last_done_cyc - start_cyc), (b == 11'd0) ? 64'd1 : 64'd17);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [10:0] b;
        logic [31:0] prev_q;
        int          d1;
        int          n0;

        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q",    64'(q),    64'd0);
        chk("rst_r",    64'(r),    64'd0);
        chk("rst_dz",   64'(dz),   64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(32'd100, 11'd7);
        do_op(32'hFFFF_FF9C, 11'd7);
        do_op(32'd100, 11'h7F9);
        do_op(32'h7FFF_FFFF, 11'd1023);
        do_op(32'h8000_0000, 11'h400);
        do_op(32'd0, 11'h7FB);
        do_op(32'h8000_0000, 11'h7FF);
        do_op(32'd5, 11'd0);
        do_op(32'hFFFF_FFFB, 11'd0);
        do_op(32'h8000_0000, 11'd1);
        do_op(32'd100, 11'd7);

        // Spec-literal spot checks independent of the model
        chk("lit_q_100_7", 64'(q), 64'd14);
        chk("lit_r_100_7", 64'(r), 64'd2);

        // Back-to-back: start issued in the done cycle
        d1 = last_done_cyc;
        do_op(32'd12345, 11'd99);
        chk("b2b_spacing", 64'(last_done_cyc - d1), 64'd18);

        // Reset in the middle of an operation: no done, outputs cleared
        x     = 32'd77777;
        y     = 11'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n0    = done_cnt;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q",    64'(q),    64'd0);
        chk("abort_r",    64'(r),    64'd0);
        chk("abort_dz",   64'(dz),   64'd0);
        chk("abort_ovf",  64'(ovf),  64'd0);
        repeat (25) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - n0), 64'd0);
        do_op(32'd1000, 11'h7FD);

        // Start pulses while busy are ignored and q holds the previous result
        prev_q = ref_div(32'd1000, 11'h7FD).q;
        fork
            do_op(32'd1234567, 11'd100);
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    x     = $urandom;
                    y     = 11'd0;
                    start = 1'b1;
                    chk("hold_q",    64'(q),    64'(prev_q));
                    chk("hold_busy", 64'(busy), 64'd1);
                    @(negedge clk);
                end
                start = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("no_queued_op", 64'(sb.size()), 64'd0);

        // Random sweep, error cases excluded
        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            b = 11'($urandom_range(1, 2047));
            if (i % 4 == 0) a = {{21{a[31]}}, a[10:0]};
            if (i % 8 == 1) b = {{8{b[10]}}, b[2:0]};
            if (b == 11'd0) b = 11'd3;
            if (a == 32'h8000_0000 && b == 11'h7FF) b = 11'd1;
            do_op(a, b);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
